// File: rtl/solver_feeder_pkg.sv
// solver_feeder_pkg
//   Shared definitions for the solver front end: the feeder state encoding
//   and the iteration-count width common to solver and solver_feeder.
//   No ports; imported with import solver_feeder_pkg::*.

package solver_feeder_pkg;

   localparam int SOLVER_ITER_BITS = 16;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_LOAD      = 4'd1,
      ST_ZFILL     = 4'd2,
      ST_DRAIN     = 4'd3,
      ST_CONFIG    = 4'd4,
      ST_START     = 4'd5,
      ST_WAIT_BUSY = 4'd6,
      ST_WAIT_DONE = 4'd7,
      ST_RESULT    = 4'd8
   } feeder_state_t;

   // States in which the limb stream may be accepted.
   function automatic logic accepts_limbs(feeder_state_t s);
      return (s == ST_IDLE) || (s == ST_LOAD) || (s == ST_DRAIN);
   endfunction

endpackage

// File: rtl/solver_feeder.sv
// solver_feeder
//   Sequencer in front of the solver. Takes one pixel job as a limb-serial
//   stream of c = cre + i*cim, writes the limbs into the solver (zero-filling
//   short jobs, discarding the excess of long ones), writes num-limbs and
//   iteration limit only when they change, pulses start, waits for the solver
//   to finish and returns the iteration count on a valid/ready port.
//   Optional: define SOLVER_FEEDER_TAG_EN to carry in_tag through to res_tag;
//   without it res_tag is tied to 0 and in_tag is ignored.
//
// Ports
//   clock, reset (async, active low)
//   cfg_num_limbs, cfg_iter_lim   job config, sampled on the first limb
//   in_valid/in_ready, in_re_limb, in_im_limb, in_last, in_tag   limb stream
//   wr_real_en, wr_imag_en, wr_index, real_data, imag_data       limb writes
//   wr_num_limbs_en/num_limbs_data, wr_iter_lim_en/iter_lim_data config writes
//   start, out_ready, iterations                                 solver control
//   res_valid/res_ready, res_iterations, res_tag, res_overrun    result port
//
// State      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | waiting for the first limb of a job
// LOAD       | writing streamed limbs, index 1 upward
// ZFILL      | job ended early, writing zero limbs up to N-1
// DRAIN      | all N limbs written, discarding the rest up to in_last
// CONFIG     | writing num-limbs / iteration limit if changed (one cycle)
// START      | pulsing solver start
// WAIT_BUSY  | waiting for the solver to drop out_ready
// WAIT_DONE  | waiting for out_ready to return, then capturing iterations
// RESULT     | holding the result until res_ready

module solver_feeder
   import solver_feeder_pkg::*;
#(
   parameter int LIMB_INDEX_BITS = 6,
   parameter int LIMB_SIZE_BITS  = 27,
   parameter int TAG_BITS        = 16
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [LIMB_INDEX_BITS-1:0]  cfg_num_limbs,
   input  logic [SOLVER_ITER_BITS-1:0] cfg_iter_lim,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [LIMB_SIZE_BITS-1:0]   in_re_limb,
   input  logic [LIMB_SIZE_BITS-1:0]   in_im_limb,
   input  logic                        in_last,
   input  logic [TAG_BITS-1:0]         in_tag,
   output logic                        wr_real_en,
   output logic                        wr_imag_en,
   output logic [LIMB_INDEX_BITS-1:0]  wr_index,
   output logic [LIMB_SIZE_BITS-1:0]   real_data,
   output logic [LIMB_SIZE_BITS-1:0]   imag_data,
   output logic                        wr_num_limbs_en,
   output logic [LIMB_INDEX_BITS-1:0]  num_limbs_data,
   output logic                        wr_iter_lim_en,
   output logic [SOLVER_ITER_BITS-1:0] iter_lim_data,
   output logic                        start,
   input  logic                        out_ready,
   input  logic [SOLVER_ITER_BITS-1:0] iterations,
   output logic                        res_valid,
   input  logic                        res_ready,
   output logic [SOLVER_ITER_BITS-1:0] res_iterations,
   output logic [TAG_BITS-1:0]         res_tag,
   output logic                        res_overrun
);

   localparam logic [LIMB_INDEX_BITS-1:0] IDX_ONE = 1;

   feeder_state_t state, state_nxt;

   logic                        hs;
   logic [LIMB_INDEX_BITS-1:0]  n_first;
   logic [LIMB_INDEX_BITS-1:0]  n_q;
   logic [SOLVER_ITER_BITS-1:0] iter_q;
   logic [LIMB_INDEX_BITS-1:0]  idx_q;
   // Down-counter of limb slots still to be written; terminal count is 1
   // (the slot being written now is the last one, index N-1).
   logic [LIMB_INDEX_BITS-1:0]  left_q;
   logic                        overrun_q;
   logic                        nl_valid_q, il_valid_q;
   logic [LIMB_INDEX_BITS-1:0]  nl_shadow_q;
   logic [SOLVER_ITER_BITS-1:0] il_shadow_q;

   logic take_first, wr_limb, wr_zero, set_overrun, capture, res_done;

   assign hs      = in_valid & in_ready;
   assign n_first = (cfg_num_limbs == '0) ? IDX_ONE : cfg_num_limbs;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      take_first  = 1'b0;
      wr_limb     = 1'b0;
      wr_zero     = 1'b0;
      set_overrun = 1'b0;
      capture     = 1'b0;
      res_done    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (hs) begin
               take_first = 1'b1;
               wr_limb    = 1'b1;
               // N == 1 is complete after limb 0: either done or draining.
               if (in_last)
                  state_nxt = (n_first == IDX_ONE) ? ST_CONFIG : ST_ZFILL;
               else
                  state_nxt = (n_first == IDX_ONE) ? ST_DRAIN : ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (hs) begin
               wr_limb = 1'b1;
               if (in_last)
                  state_nxt = (left_q == IDX_ONE) ? ST_CONFIG : ST_ZFILL;
               else if (left_q == IDX_ONE)
                  state_nxt = ST_DRAIN;
            end
         end
         ST_ZFILL: begin
            wr_zero = 1'b1;
            if (left_q == IDX_ONE) state_nxt = ST_CONFIG;
         end
         ST_DRAIN: begin
            if (hs && in_last) begin
               set_overrun = 1'b1;
               state_nxt   = ST_CONFIG;
            end
         end
         ST_CONFIG:    state_nxt = ST_START;
         ST_START:     state_nxt = ST_WAIT_BUSY;
         ST_WAIT_BUSY: if (!out_ready) state_nxt = ST_WAIT_DONE;
         ST_WAIT_DONE: begin
            if (out_ready) begin
               capture   = 1'b1;
               state_nxt = ST_RESULT;
            end
         end
         ST_RESULT: begin
            if (res_ready) begin
               res_done  = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         in_ready        <= 1'b0;
         wr_real_en      <= 1'b0;
         wr_imag_en      <= 1'b0;
         wr_index        <= '0;
         real_data       <= '0;
         imag_data       <= '0;
         wr_num_limbs_en <= 1'b0;
         num_limbs_data  <= '0;
         wr_iter_lim_en  <= 1'b0;
         iter_lim_data   <= '0;
         start           <= 1'b0;
         res_valid       <= 1'b0;
         res_iterations  <= '0;
         res_overrun     <= 1'b0;
         n_q             <= '0;
         iter_q          <= '0;
         idx_q           <= '0;
         left_q          <= '0;
         overrun_q       <= 1'b0;
         nl_valid_q      <= 1'b0;
         il_valid_q      <= 1'b0;
         nl_shadow_q     <= '0;
         il_shadow_q     <= '0;
      end else begin
         // Registered from the next state so it lines up with the state
         // that will consume the handshake.
         in_ready   <= accepts_limbs(state_nxt);
         wr_real_en <= wr_limb | wr_zero;
         wr_imag_en <= wr_limb | wr_zero;
         start      <= (state == ST_START);

         if (wr_limb | wr_zero) begin
            wr_index  <= take_first ? '0 : idx_q;
            real_data <= wr_zero ? '0 : in_re_limb;
            imag_data <= wr_zero ? '0 : in_im_limb;
         end

         if (take_first) begin
            n_q       <= n_first;
            iter_q    <= cfg_iter_lim;
            idx_q     <= IDX_ONE;
            left_q    <= n_first - IDX_ONE;
            overrun_q <= 1'b0;
         end else if (wr_limb | wr_zero) begin
            idx_q  <= idx_q + IDX_ONE;
            left_q <= left_q - IDX_ONE;
         end

         if (set_overrun) overrun_q <= 1'b1;

         wr_num_limbs_en <= 1'b0;
         wr_iter_lim_en  <= 1'b0;
         if (state == ST_CONFIG) begin
            if (!nl_valid_q || (nl_shadow_q != n_q)) begin
               wr_num_limbs_en <= 1'b1;
               num_limbs_data  <= n_q;
            end
            if (!il_valid_q || (il_shadow_q != iter_q)) begin
               wr_iter_lim_en <= 1'b1;
               iter_lim_data  <= iter_q;
            end
            nl_shadow_q <= n_q;
            il_shadow_q <= iter_q;
            nl_valid_q  <= 1'b1;
            il_valid_q  <= 1'b1;
         end

         if (capture) begin
            res_valid      <= 1'b1;
            res_iterations <= iterations;
            res_overrun    <= overrun_q;
         end else if (res_done) begin
            res_valid <= 1'b0;
         end
      end
   end

`ifdef SOLVER_FEEDER_TAG_EN
   logic [TAG_BITS-1:0] tag_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tag_q   <= '0;
         res_tag <= '0;
      end else begin
         if (take_first) tag_q <= in_tag;
         if (capture)    res_tag <= tag_q;
      end
   end
`else
   assign res_tag = '0;
`endif

endmodule
